// File: rtl/functional_counter_if.sv
// Data-side bundle for functional_counter: load value, opcode, counter value and terminal count.
interface functional_counter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] d;
  logic [1:0]       op;
  logic [WIDTH-1:0] q;
  logic             tc;

  modport master (output d, output op, input q, input tc);
  modport slave  (input d, input op, output q, output tc);
endinterface

// File: rtl/functional_counter.sv
// Loadable up/down counter with hold and a direction-aware terminal count flag.
// Define FUNCTIONAL_COUNTER_SAT_EN to make counting saturate at the ends instead of wrapping.
module functional_counter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 aclr,
  functional_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_HOLD = 2'b11
  } op_e;

  op_e             op;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;
  logic             at_max;
  logic             at_min;

  assign op     = op_e'(bus.op);
  assign at_max = (q_r == {WIDTH{1'b1}});
  assign at_min = (q_r == '0);

  always_comb begin
    // NOTE: default assigned first so every path drives q_next and no latch is inferred.
    q_next = q_r;
    unique case (op)
      OP_LOAD: q_next = bus.d;
`ifdef FUNCTIONAL_COUNTER_SAT_EN
      OP_UP:   q_next = at_max ? q_r : q_r + 1'b1;
      OP_DOWN: q_next = at_min ? q_r : q_r - 1'b1;
`else
      OP_UP:   q_next = q_r + 1'b1;
      OP_DOWN: q_next = q_r - 1'b1;
`endif
      OP_HOLD: q_next = q_r;
      default: q_next = q_r;
    endcase
  end

  // aclr is synchronous and outranks every opcode.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    if (aclr) q_r <= '0;
    else      q_r <= q_next;
  end

  assign bus.q  = q_r;
  assign bus.tc = ((op == OP_UP) && at_max) || ((op == OP_DOWN) && at_min);

endmodule

// File: tb/tb_functional_counter.sv
// Randomised self-checking bench for functional_counter against an arithmetic reference model.
module tb_functional_counter;
  localparam int WIDTH = 8;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic clk = 1'b0;
  logic aclr;
  int   total = 0;
  int   bad   = 0;
  int   model_q = 0;
  bit   model_valid = 1'b0;

  functional_counter_if #(.WIDTH(WIDTH)) bus ();

  functional_counter #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .aclr (aclr),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_next(input int q, input int op, input int d);
    case (op)
      0: return d;
`ifdef FUNCTIONAL_COUNTER_SAT_EN
      1: return (q == MAXV) ? q : q + 1;
      2: return (q == 0) ? q : q - 1;
`else
      1: return (q + 1) % (MAXV + 1);
      2: return (q + MAXV) % (MAXV + 1);
`endif
      default: return q;
    endcase
  endfunction

  function automatic int model_tc(input int q, input int op);
    if (op == 1) return (q == MAXV) ? 1 : 0;
    if (op == 2) return (q == 0) ? 1 : 0;
    return 0;
  endfunction

  // Drive inputs mid-cycle, check tc combinationally, then check q/tc after the edge.
  task automatic step(input logic a, input logic [1:0] o, input logic [WIDTH-1:0] dv);
    @(negedge clk);
    aclr   = a;
    bus.op = o;
    bus.d  = dv;
    #1;
    if (model_valid) check("tc_pre", {31'b0, bus.tc}, model_tc(model_q, int'(o)));
    @(posedge clk);
    #1;
    model_q     = a ? 0 : model_next(model_q, int'(o), int'(dv));
    model_valid = 1'b1;
    check("q", {24'b0, bus.q}, model_q);
    check("tc_post", {31'b0, bus.tc}, model_tc(model_q, int'(o)));
  endtask

  initial begin
    aclr   = 1'b0;
    bus.op = 2'b11;
    bus.d  = '0;

    // Reset beats load.
    step(1'b1, 2'b00, 8'hFF);
    check("plan_reset_q", {24'b0, bus.q}, 32'h00);
    check("plan_reset_tc", {31'b0, bus.tc}, 32'h0);

    step(1'b0, 2'b01, 8'h0F);
    check("plan_up1", {24'b0, bus.q}, 32'h01);
    step(1'b0, 2'b01, 8'h0F);
    check("plan_up2", {24'b0, bus.q}, 32'h02);

    step(1'b0, 2'b10, 8'hFF);
    step(1'b0, 2'b10, 8'hFF);
    check("plan_down0", {24'b0, bus.q}, 32'h00);
    check("plan_down_tc", {31'b0, bus.tc}, 32'h1);

    step(1'b0, 2'b00, 8'hFF);
    check("plan_load_ff_tc", {31'b0, bus.tc}, 32'h0);
    step(1'b0, 2'b01, 8'h00);
`ifdef FUNCTIONAL_COUNTER_SAT_EN
    check("plan_sat_up", {24'b0, bus.q}, 32'hFF);
    check("plan_sat_up_tc", {31'b0, bus.tc}, 32'h1);
    step(1'b0, 2'b00, 8'h00);
    step(1'b0, 2'b10, 8'h55);
    check("plan_sat_down", {24'b0, bus.q}, 32'h00);
`else
    check("plan_wrap_up", {24'b0, bus.q}, 32'h00);
    step(1'b0, 2'b10, 8'h00);
    check("plan_wrap_down", {24'b0, bus.q}, 32'hFF);
`endif

    step(1'b0, 2'b00, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b11, 8'h3C);
      check("plan_hold", {24'b0, bus.q}, 32'hA5);
    end
    step(1'b1, 2'b01, 8'h77);
    check("plan_reset_mid", {24'b0, bus.q}, 32'h00);
    step(1'b0, 2'b01, 8'h77);
    check("plan_resume", {24'b0, bus.q}, 32'h01);

    // Random traffic biased towards the wrap/saturation boundaries.
    for (int i = 0; i < 400; i++) begin
      logic            a;
      logic [1:0]      o;
      logic [WIDTH-1:0] dv;
      a  = ($urandom_range(0, 19) == 0);
      o  = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       dv = '0;
        1:       dv = '1;
        default: dv = WIDTH'($urandom);
      endcase
      step(a, o, dv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
